// File: rtl/block_scan_counter.sv
// block_scan_counter
//
// Coefficient-position generator for square 2^N_LOG2 x 2^N_LOG2 transform
// blocks. Each accepted start produces one complete scan in raster,
// column-major or JPEG zigzag order. Positions are offered over a
// valid/ready handshake, so a downstream quantiser or RLE stage can stall
// the scan.
//
// Parameters
//   N_LOG2  log2 of the block side (legal 1..5), block side N = 2^N_LOG2
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request a scan; only honoured in IDLE
//   abort  in   synchronous cancel; wins over start and ready
//   mode   in   scan order, captured on an accepted start
//               00 raster (v inner), 01 column-major (u inner),
//               10 zigzag, 11 raster
//   ready  in   consumer takes the current position
//   valid  out  a position is presented
//   u      out  row of the current position
//   v      out  column of the current position
//   idx    out  scan-order index of the current position, 0..N*N-1
//   last   out  current position is the final one of the scan
//   busy   out  a scan is in progress
//   done   out  one-cycle pulse after the final position is accepted
//
// FSM states
//   state | meaning
//   IDLE  | no scan in progress; waiting for start
//   RUN   | presenting positions; advances on each valid & ready beat
//
// Every output is a register or a decode of registers only.

module block_scan_counter #(
    parameter int N_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic                  ready,
    output logic                  valid,
    output logic [N_LOG2-1:0]     u,
    output logic [N_LOG2-1:0]     v,
    output logic [2*N_LOG2-1:0]   idx,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_COLUMN = 2'b01;
    localparam logic [1:0] MODE_ZIGZAG = 2'b10;

    // Block side minus one, and N*N-1: both are all-ones in their widths.
    localparam logic [N_LOG2-1:0]   POS_MAX = {N_LOG2{1'b1}};
    localparam logic [2*N_LOG2-1:0] IDX_MAX = {(2*N_LOG2){1'b1}};
    localparam logic [N_LOG2-1:0]   POS_ONE = N_LOG2'(1);

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [N_LOG2-1:0]     u_q, u_d;
    logic [N_LOG2-1:0]     v_q, v_d;
    logic [2*N_LOG2-1:0]   idx_q, idx_d;
    logic                  done_q, done_d;

    logic [N_LOG2-1:0]     u_adv;
    logic [N_LOG2-1:0]     v_adv;
    logic                  diag_even;

    // u+v is even exactly when the low bits of u and v agree.
    assign diag_even = ~(u_q[0] ^ v_q[0]);

    // Position that follows (u_q, v_q) in the captured scan order.
    // Zigzag direction is recovered from the diagonal parity, so no
    // separate direction state is kept.
    always_comb begin
        u_adv = u_q;
        v_adv = v_q;
        case (mode_q)
            MODE_COLUMN: begin
                if (u_q == POS_MAX) begin
                    u_adv = '0;
                    v_adv = v_q + POS_ONE;
                end else begin
                    u_adv = u_q + POS_ONE;
                end
            end
            MODE_ZIGZAG: begin
                if (diag_even) begin
                    // moving up-right
                    if (v_q == POS_MAX) begin
                        u_adv = u_q + POS_ONE;
                    end else if (u_q == '0) begin
                        v_adv = v_q + POS_ONE;
                    end else begin
                        u_adv = u_q - POS_ONE;
                        v_adv = v_q + POS_ONE;
                    end
                end else begin
                    // moving down-left
                    if (u_q == POS_MAX) begin
                        v_adv = v_q + POS_ONE;
                    end else if (v_q == '0) begin
                        u_adv = u_q + POS_ONE;
                    end else begin
                        u_adv = u_q + POS_ONE;
                        v_adv = v_q - POS_ONE;
                    end
                end
            end
            default: begin
                // raster, including the unused 11 encoding
                if (v_q == POS_MAX) begin
                    v_adv = '0;
                    u_adv = u_q + POS_ONE;
                end else begin
                    v_adv = v_q + POS_ONE;
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        u_d     = u_q;
        v_d     = v_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mode_d  = mode;
                    u_d     = '0;
                    v_d     = '0;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (ready) begin
                    if (idx_q == IDX_MAX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        u_d     = '0;
                        v_d     = '0;
                        idx_d   = '0;
                    end else begin
                        u_d   = u_adv;
                        v_d   = v_adv;
                        idx_d = idx_q + {{(2*N_LOG2-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cancel overrides everything else, including a completing beat.
        if (abort) begin
            state_d = IDLE;
            u_d     = '0;
            v_d     = '0;
            idx_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            u_q     <= '0;
            v_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            u_q     <= u_d;
            v_q     <= v_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign valid = (state_q == RUN);
    assign busy  = (state_q == RUN);
    assign u     = u_q;
    assign v     = v_q;
    assign idx   = idx_q;
    assign last  = (state_q == RUN) && (idx_q == IDX_MAX);
    assign done  = done_q;

endmodule

// File: tb/tb_block_scan_counter.sv
module tb_block_scan_counter;

    logic clk = 1'b0;
    logic rst;
    logic start, abort, ready, sel;
    logic [1:0] mode;

    always #5 clk = ~clk;

    // sel = 0 drives the 8x8 instance, sel = 1 the 4x4 instance
    logic start8, abort8, start4, abort4;
    assign start8 = start & ~sel;
    assign abort8 = abort & ~sel;
    assign start4 = start & sel;
    assign abort4 = abort & sel;

    logic       valid8, last8, busy8, done8;
    logic [2:0] u8, v8;
    logic [5:0] idx8;
    logic       valid4, last4, busy4, done4;
    logic [1:0] u4, v4;
    logic [3:0] idx4;

    block_scan_counter #(.N_LOG2(3)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8), .mode(mode),
        .ready(ready), .valid(valid8), .u(u8), .v(v8), .idx(idx8),
        .last(last8), .busy(busy8), .done(done8)
    );

    block_scan_counter #(.N_LOG2(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4), .mode(mode),
        .ready(ready), .valid(valid4), .u(u4), .v(v4), .idx(idx4),
        .last(last4), .busy(busy4), .done(done4)
    );

    logic        o_valid, o_last, o_busy, o_done;
    logic [31:0] o_u, o_v, o_idx;
    assign o_valid = sel ? valid4 : valid8;
    assign o_last  = sel ? last4  : last8;
    assign o_busy  = sel ? busy4  : busy8;
    assign o_done  = sel ? done4  : done8;
    assign o_u     = sel ? 32'(u4)   : 32'(u8);
    assign o_v     = sel ? 32'(v4)   : 32'(v8);
    assign o_idx   = sel ? 32'(idx4) : 32'(idx8);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    typedef struct {
        int u;
        int v;
        int idx;
        bit last;
    } pos_t;

    pos_t exp_q[$];

    // Reference order: zigzag walks anti-diagonals s = u+v, rows ascending
    // on odd diagonals and descending on even ones.
    task automatic build_expected(input int nl, input logic [1:0] m);
        int n, k, lo, hi;
        pos_t p;
        n = 1 << nl;
        k = 0;
        exp_q.delete();
        if (m == 2'b10) begin
            for (int s = 0; s <= 2*n-2; s++) begin
                lo = (s - n + 1 < 0) ? 0 : s - n + 1;
                hi = (s < n - 1) ? s : n - 1;
                for (int j = 0; j <= hi - lo; j++) begin
                    p.u = (s % 2 == 1) ? lo + j : hi - j;
                    p.v = s - p.u;
                    p.idx = k;
                    p.last = (k == n*n-1);
                    exp_q.push_back(p);
                    k++;
                end
            end
        end else begin
            for (int i = 0; i < n*n; i++) begin
                p.u = (m == 2'b01) ? i % n : i / n;
                p.v = (m == 2'b01) ? i / n : i % n;
                p.idx = i;
                p.last = (i == n*n-1);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic run_scan(input bit use4, input logic [1:0] m, input bit rnd,
                            input bit start_mid, input bit chain);
        int n, total, stalls, valids, cyc, distinct;
        longint held;
        bit hold_pending, exp_done, fin;
        bit seen [0:63];
        pos_t e;
        n = use4 ? 4 : 8;
        total = n * n;
        stalls = 0; valids = 0; cyc = 0; distinct = 0;
        hold_pending = 0; exp_done = 0; fin = 0; held = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        sel = use4;
        build_expected(use4 ? 2 : 3, m);

        @(negedge clk);
        mode = m; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_valid", o_valid, 1);

        while (!fin && cyc < 600) begin
            if (hold_pending) begin
                check("stall_hold", (longint'(o_u) << 16) | (longint'(o_v) << 8) | o_idx, held);
                hold_pending = 0;
            end
            if (exp_done) begin
                check("done_pulse", o_done, 1);
                check("done_valid", o_valid, 0);
                if (chain) begin
                    start = 1'b1;
                    mode = m;
                end
                fin = 1;
            end else if (o_valid) begin
                valids++;
                if (start_mid) begin
                    start = (o_idx == 5);
                    mode  = (o_idx == 5) ? ~m : m;
                end
                ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (ready) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("beat_u", o_u, e.u);
                        check("beat_v", o_v, e.v);
                        check("beat_idx", o_idx, e.idx);
                        check("beat_last", o_last, e.last);
                        if (!seen[o_u*n + o_v]) distinct++;
                        seen[o_u*n + o_v] = 1'b1;
                        if (e.last) exp_done = 1;
                    end else begin
                        check("extra_beat", exp_q.size(), 1);
                        fin = 1;
                    end
                end else begin
                    stalls++;
                    hold_pending = 1;
                    held = (longint'(o_u) << 16) | (longint'(o_v) << 8) | o_idx;
                end
            end else begin
                check("valid_drop", o_valid, 1);
                fin = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        mode = m;
        check("scan_finished", fin, 1);
        check("done_one_cycle", o_done, 0);
        check("valid_cycles", valids, total + stalls);
        check("distinct_positions", distinct, total);
        if (chain) begin
            check("chain_valid", o_valid, 1);
            check("chain_idx", o_idx, 0);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("chain_abort_idle", o_busy, 0);
        end else begin
            check("after_scan_idle", o_valid, 0);
        end
    endtask

    task automatic abort_test();
        int cyc;
        bit any_done;
        sel = 1'b0;
        cyc = 0;
        any_done = 0;
        @(negedge clk);
        mode = 2'b00; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (o_idx != 20 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_20", o_idx, 20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", o_valid, 0);
        check("abort_busy", o_busy, 0);
        check("abort_pos", (longint'(o_u) << 16) | (longint'(o_v) << 8) | o_idx, 0);
        for (int i = 0; i < 3; i++) begin
            if (o_done) any_done = 1;
            @(negedge clk);
        end
        check("abort_no_done", any_done, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; ready = 1'b0; sel = 1'b0; mode = 2'b00;
        #12;
        check("rst_valid", valid8, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_last", last8, 0);
        check("rst_pos", {u8, v8, idx8}, 0);
        @(negedge clk);
        rst = 1'b0;

        run_scan(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);   // raster, start in done cycle
        run_scan(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);   // zigzag 8x8
        run_scan(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);   // raster with backpressure
        run_scan(1'b0, 2'b10, 1'b1, 1'b0, 1'b0);   // zigzag with backpressure
        run_scan(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);   // start and mode change mid-scan
        abort_test();

        @(negedge clk);
        sel = 1'b0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle_busy", o_busy, 0);
        check("start_abort_idle_valid", o_valid, 0);

        run_scan(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);   // column-major 4x4
        run_scan(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);   // zigzag 4x4
        run_scan(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);   // mode 11 behaves as raster

        // asynchronous reset in the middle of a scan
        sel = 1'b0;
        @(negedge clk);
        mode = 2'b00; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_busy", o_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", o_valid, 0);
        check("async_rst_pos", (longint'(o_u) << 16) | (longint'(o_v) << 8) | o_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", o_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/block_scan_counter.md
# block_scan_counter

Parametrised coefficient-position generator for square 2^N_LOG2 x 2^N_LOG2 transform blocks. One scan per start request, in raster, column-major or JPEG zigzag order. Positions are presented as (u, v) with a linear scan index over a valid/ready handshake, so the quantiser or entropy stage can stall the scan. It sits between the transform block buffer (read addressing) and the quantiser/RLE front end, and replaces the fixed 8x8 raster double counter.

## Interface

Parameters:
- N_LOG2, default 3: log2 of block side; block side N = 2^N_LOG2; legal range 1..5.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new scan; accepted only in IDLE.
- abort  input  1  synchronous cancel of any scan in progress.
- mode  input  2  scan order, sampled on accepted start: 00 raster (v inner), 01 column-major (u inner), 10 zigzag, 11 treated as raster.
- ready  input  1  consumer accepts current position.
- valid  output  1  a position is presented.
- u  output  N_LOG2  row of current position.
- v  output  N_LOG2  column of current position.
- idx  output  2*N_LOG2  scan-order index of current position, 0..N*N-1.
- last  output  1  current position is the final one (idx == N*N-1); qualified by valid.
- busy  output  1  state is RUN.
- done  output  1  one-cycle pulse after the last position is accepted.

## Operation

- States: IDLE, RUN. Mode register captured at start, held for the whole scan; mode changes during RUN are ignored.
- IDLE: valid=0, busy=0. If start=1 and abort=0, go to RUN with u=v=idx=0.
- RUN: valid=1, busy=1. A beat transfers when valid & ready; on transfer idx increments and (u, v) advances per mode. Without ready, all outputs hold.
- Raster advance: v+1; on v==N-1, v wraps to 0 and u+1.
- Column-major advance: u+1; on u==N-1, u wraps to 0 and v+1.
- Zigzag advance is purely a function of the current (u, v), with no direction register:
  - If u+v is even: when v==N-1, u+1; else when u==0, v+1; else u-1, v+1.
  - If u+v is odd: when u==N-1, v+1; else when v==0, u+1; else u+1, v-1.
- Transfer with last=1: next state is IDLE, done=1 for that next cycle, and u/v/idx return to 0.
- abort=1 in any state: next state is IDLE, u/v/idx=0, no done pulse. abort has priority over start and ready.
- start during RUN is ignored and is not queued.
- start in the cycle done is high is accepted, because the block is already in IDLE. This gives back-to-back scans with one bubble cycle.

## Timing

- Reset values: valid=0, busy=0, done=0, last=0, u=0, v=0, idx=0, state IDLE, mode register 00.
- Start latency: start accepted at edge k gives valid=1 with position 0 from cycle k+1.
- Throughput: one position per cycle while ready=1. A full scan takes N*N cycles, plus one IDLE cycle carrying done.
- Outputs u/v/idx/last/valid/busy/done are registered or decoded from registers only. There is no combinational path from ready, start or abort to any output.
- last = valid & (idx == N*N-1), decoded from registers.
- idx wraps only via the return to IDLE; it never counts past N*N-1.
- Reset asserted mid-scan forces the reset values immediately, asynchronously. Deassertion leaves the block in IDLE.

## Test plan

- Reset and raster: N_LOG2=3, mode=00, ready=1, pulse start.
  - Beat k shows u=k>>3, v=k&7, idx=k.
  - last=1 only at idx 63.
  - done=1 exactly one cycle after beat 63; valid=0 that cycle.
- Zigzag 8x8, ready=1:
  - First ten beats: (0,0),(0,1),(1,0),(2,0),(1,1),(0,2),(0,3),(1,2),(2,1),(3,0).
  - idx 61=(6,7), 62=(7,6), 63=(7,7) with last=1.
  - All 64 positions appear exactly once.
- Backpressure: raster mode with ready toggling pseudo-randomly.
  - With ready=0, u/v/idx hold.
  - Sequence matches the ready=1 run.
  - Total valid cycles equals 64 plus the number of stall cycles.
- Abort and start interactions:
  - abort at idx 20 gives valid=0 next cycle, no done, u=v=idx=0.
  - start during RUN changes nothing.
  - start and abort together in IDLE keep the block in IDLE.
  - start in the done cycle begins a new scan at position 0.
- Column-major and small block: N_LOG2=2, mode=01.
  - Beat k shows u=k&3, v=k>>2.
  - With mode=10: the 16 beats end (2,3),(3,2),(3,3) with last at idx 15.
  - With mode=11: the order is raster.
